// File: rtl/writeback_regfile.sv
// Writeback stage and 32x32 architectural register file for the RV32 pipeline.
// Two write-first bypassed read ports, a free-running cycle counter and a retired-write counter.

module wb_read_port (
  input  logic [4:0]        addr,
  input  logic [31:0][31:0] regs,
  input  logic              w_reg,
  input  logic [4:0]        wr_addr,
  input  logic [31:0]       wr_data,
  output logic [31:0]       data
);

  // x0 is hard zero; otherwise an in-flight writeback wins over the array.
  always_comb begin
    data = '0;
    if (addr != 5'd0) begin
      if (w_reg && (addr == wr_addr)) data = wr_data;
      else                            data = regs[addr];
    end
  end

endmodule

module writeback_regfile #(
  parameter logic [31:0] SP_INIT = 32'h0001_0000,
  parameter logic [31:0] GP_INIT = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] rd_data,
  input  logic        w_reg,
  input  logic [4:0]  dst_addrD,
  input  logic [4:0]  rs1_addr,
  input  logic [4:0]  rs2_addr,
  output logic [31:0] rs1_data,
  output logic [31:0] rs2_data,
  input  logic        hc_clear,
  output logic [31:0] hc_OUT_data,
  output logic [31:0] retire_count
);

  localparam int NUM_RD = 2;

  logic [31:0][31:0]       regs;
  logic [31:0]             hc_cnt;
  logic [31:0]             retire_cnt;
  logic                    wr_commit;
  logic [NUM_RD-1:0][4:0]  rd_addr;
  logic [NUM_RD-1:0][31:0] rd_dout;

  assign wr_commit = w_reg && (dst_addrD != 5'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
      regs[2] <= SP_INIT;
      regs[3] <= GP_INIT;
    end else if (wr_commit) begin
      regs[dst_addrD] <= rd_data;
    end
  end

  // Clear wins over increment; wrap at 2^32 is silent.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        hc_cnt <= '0;
    else if (hc_clear) hc_cnt <= '0;
    else               hc_cnt <= hc_cnt + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         retire_cnt <= '0;
    else if (wr_commit) retire_cnt <= retire_cnt + 32'd1;
  end

  assign rd_addr[0] = rs1_addr;
  assign rd_addr[1] = rs2_addr;

  for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
    wb_read_port u_rd (
      .addr    (rd_addr[g]),
      .regs    (regs),
      .w_reg   (w_reg),
      .wr_addr (dst_addrD),
      .wr_data (rd_data),
      .data    (rd_dout[g])
    );
  end

  assign rs1_data     = rd_dout[0];
  assign rs2_data     = rd_dout[1];
  assign hc_OUT_data  = hc_cnt;
  assign retire_count = retire_cnt;

endmodule

// File: tb/tb_writeback_regfile.sv
// Self-checking bench for writeback_regfile: directed scenarios plus randomized traffic
// compared against an array-based reference model.

module tb_writeback_regfile;

  localparam logic [31:0] SP = 32'h0001_0000;
  localparam logic [31:0] GP = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] rd_data = '0;
  logic        w_reg = 1'b0;
  logic [4:0]  dst_addrD = '0;
  logic [4:0]  rs1_addr = '0;
  logic [4:0]  rs2_addr = '0;
  logic [31:0] rs1_data, rs2_data;
  logic        hc_clear = 1'b0;
  logic [31:0] hc_OUT_data, retire_count;

  int pass_cnt = 0;
  int total_cnt = 0;

  logic [31:0] m_regs [32];
  logic [31:0] m_hc;
  logic [31:0] m_ret;

  writeback_regfile #(.SP_INIT(SP), .GP_INIT(GP)) dut (
    .clk(clk), .rst_n(rst_n), .rd_data(rd_data), .w_reg(w_reg), .dst_addrD(dst_addrD),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .hc_clear(hc_clear), .hc_OUT_data(hc_OUT_data), .retire_count(retire_count)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_regs[i] = '0;
    m_regs[2] = SP;
    m_regs[3] = GP;
    m_hc  = '0;
    m_ret = '0;
  endtask

  function automatic logic [31:0] model_read(input logic [4:0] a);
    if (a == 5'd0) return '0;
    if (w_reg && a == dst_addrD) return rd_data;
    return m_regs[a];
  endfunction

  // One rising edge; the model takes the inputs held across it, then inputs may change.
  task automatic clk_edge();
    @(posedge clk);
    if (rst_n) begin
      m_hc = hc_clear ? 32'd0 : m_hc + 32'd1;
      if (w_reg && dst_addrD != 5'd0) begin
        m_regs[dst_addrD] = rd_data;
        m_ret = m_ret + 32'd1;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; w_reg = 1'b0; hc_clear = 1'b0;
    model_reset();
    clk_edge();
    rs1_addr = 5'd2; rs2_addr = 5'd3;
    #1;
    total_cnt++; if (rs1_data !== SP) $display("FAIL reset_x2: got %h want %h", rs1_data, SP); else pass_cnt++;
    total_cnt++; if (rs2_data !== GP) $display("FAIL reset_x3: got %h want %h", rs2_data, GP); else pass_cnt++;
    rs1_addr = 5'd1; rs2_addr = 5'd31;
    #1;
    total_cnt++; if (rs1_data !== 32'd0) $display("FAIL reset_x1: got %h want 0", rs1_data); else pass_cnt++;
    total_cnt++; if (rs2_data !== 32'd0) $display("FAIL reset_x31: got %h want 0", rs2_data); else pass_cnt++;
    total_cnt++; if (hc_OUT_data !== 32'd0) $display("FAIL reset_hc: got %h want 0", hc_OUT_data); else pass_cnt++;
    total_cnt++; if (retire_count !== 32'd0) $display("FAIL reset_ret: got %h want 0", retire_count); else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_write_bypass();
    logic [31:0] ret0;
    ret0 = m_ret;
    w_reg = 1'b1; dst_addrD = 5'd5; rd_data = 32'hDEAD_BEEF; rs1_addr = 5'd5;
    #1;
    total_cnt++; if (rs1_data !== 32'hDEAD_BEEF) $display("FAIL bypass_x5: got %h want deadbeef", rs1_data); else pass_cnt++;
    clk_edge();
    w_reg = 1'b0; rd_data = 32'h0;
    #1;
    total_cnt++; if (rs1_data !== 32'hDEAD_BEEF) $display("FAIL array_x5: got %h want deadbeef", rs1_data); else pass_cnt++;
    total_cnt++; if (retire_count !== ret0 + 32'd1) $display("FAIL retire_x5: got %h want %h", retire_count, ret0 + 32'd1); else pass_cnt++;
  endtask

  task automatic test_x0_write();
    logic [31:0] ret0;
    ret0 = m_ret;
    w_reg = 1'b1; dst_addrD = 5'd0; rd_data = 32'h1234_5678; rs1_addr = 5'd0;
    #1;
    total_cnt++; if (rs1_data !== 32'd0) $display("FAIL x0_bypass: got %h want 0", rs1_data); else pass_cnt++;
    clk_edge();
    w_reg = 1'b0;
    #1;
    total_cnt++; if (rs1_data !== 32'd0) $display("FAIL x0_array: got %h want 0", rs1_data); else pass_cnt++;
    total_cnt++; if (retire_count !== ret0) $display("FAIL x0_retire: got %h want %h", retire_count, ret0); else pass_cnt++;
  endtask

  task automatic test_dual_bypass();
    w_reg = 1'b1; dst_addrD = 5'd7; rd_data = 32'h0000_00A5; rs1_addr = 5'd7; rs2_addr = 5'd7;
    #1;
    total_cnt++; if (rs1_data !== 32'hA5) $display("FAIL dual_rs1: got %h want a5", rs1_data); else pass_cnt++;
    total_cnt++; if (rs2_data !== 32'hA5) $display("FAIL dual_rs2: got %h want a5", rs2_data); else pass_cnt++;
    clk_edge();
    w_reg = 1'b0;
  endtask

  task automatic test_hc_counter();
    #1;
    rst_n = 1'b0;
    model_reset();
    clk_edge();
    @(negedge clk);
    rst_n = 1'b1;
    clk_edge();
    total_cnt++; if (hc_OUT_data !== 32'd1) $display("FAIL hc_first: got %h want 1", hc_OUT_data); else pass_cnt++;
    for (int i = 0; i < 9; i++) clk_edge();
    total_cnt++; if (hc_OUT_data !== 32'd10) $display("FAIL hc_ten: got %h want 10", hc_OUT_data); else pass_cnt++;
    hc_clear = 1'b1;
    clk_edge();
    hc_clear = 1'b0;
    total_cnt++; if (hc_OUT_data !== 32'd0) $display("FAIL hc_clear: got %h want 0", hc_OUT_data); else pass_cnt++;
    clk_edge();
    total_cnt++; if (hc_OUT_data !== 32'd1) $display("FAIL hc_after_clear: got %h want 1", hc_OUT_data); else pass_cnt++;
  endtask

  task automatic test_hc_wrap();
    force dut.hc_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.hc_cnt;
    m_hc = 32'hFFFF_FFFF;
    #1;
    total_cnt++; if (hc_OUT_data !== 32'hFFFF_FFFF) $display("FAIL hc_preset: got %h want ffffffff", hc_OUT_data); else pass_cnt++;
    clk_edge();
    total_cnt++; if (hc_OUT_data !== 32'd0) $display("FAIL hc_wrap: got %h want 0", hc_OUT_data); else pass_cnt++;
  endtask

  task automatic test_async_reset();
    logic [31:0] v;
    v = $urandom | 32'h1;
    w_reg = 1'b1; dst_addrD = 5'd9; rd_data = v;
    clk_edge();
    w_reg = 1'b0; rs1_addr = 5'd9;
    #1;
    total_cnt++; if (rs1_data !== v) $display("FAIL x9_written: got %h want %h", rs1_data, v); else pass_cnt++;
    #1;
    w_reg = 1'b1; dst_addrD = 5'd10; rd_data = 32'hCAFE_0010; rs2_addr = 5'd10;
    rst_n = 1'b0;
    model_reset();
    #1;
    total_cnt++; if (rs1_data !== 32'd0) $display("FAIL areset_x9: got %h want 0", rs1_data); else pass_cnt++;
    total_cnt++; if (rs2_data !== 32'hCAFE_0010) $display("FAIL areset_bypass: got %h want cafe0010", rs2_data); else pass_cnt++;
    total_cnt++; if (hc_OUT_data !== 32'd0) $display("FAIL areset_hc: got %h want 0", hc_OUT_data); else pass_cnt++;
    total_cnt++; if (retire_count !== 32'd0) $display("FAIL areset_ret: got %h want 0", retire_count); else pass_cnt++;
    clk_edge();
    w_reg = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    total_cnt++; if (rs2_data !== 32'd0) $display("FAIL areset_no_commit: got %h want 0", rs2_data); else pass_cnt++;
    clk_edge();
    total_cnt++; if (hc_OUT_data !== 32'd1) $display("FAIL areset_hc_first: got %h want 1", hc_OUT_data); else pass_cnt++;
    total_cnt++; if (retire_count !== 32'd0) $display("FAIL areset_ret_after: got %h want 0", retire_count); else pass_cnt++;
  endtask

  task automatic test_random();
    for (int n = 0; n < 300; n++) begin
      w_reg     = ($urandom_range(3) != 0);
      dst_addrD = 5'($urandom_range(31));
      rd_data   = $urandom;
      rs1_addr  = ($urandom_range(3) == 0) ? dst_addrD : 5'($urandom_range(31));
      rs2_addr  = ($urandom_range(3) == 0) ? dst_addrD : 5'($urandom_range(31));
      hc_clear  = ($urandom_range(15) == 0);
      #1;
      total_cnt++; if (rs1_data !== model_read(rs1_addr)) $display("FAIL rand_rs1[%0d]: got %h want %h", n, rs1_data, model_read(rs1_addr)); else pass_cnt++;
      total_cnt++; if (rs2_data !== model_read(rs2_addr)) $display("FAIL rand_rs2[%0d]: got %h want %h", n, rs2_data, model_read(rs2_addr)); else pass_cnt++;
      clk_edge();
      total_cnt++; if (hc_OUT_data !== m_hc) $display("FAIL rand_hc[%0d]: got %h want %h", n, hc_OUT_data, m_hc); else pass_cnt++;
      total_cnt++; if (retire_count !== m_ret) $display("FAIL rand_ret[%0d]: got %h want %h", n, retire_count, m_ret); else pass_cnt++;
    end
    w_reg = 1'b0; hc_clear = 1'b0;
    // Sweep the whole array through port 1 with no writeback in flight.
    for (int a = 0; a < 32; a++) begin
      rs1_addr = 5'(a);
      #1;
      total_cnt++; if (rs1_data !== model_read(rs1_addr)) $display("FAIL sweep_x%0d: got %h want %h", a, rs1_data, model_read(rs1_addr)); else pass_cnt++;
    end
  endtask

  initial begin
    test_reset();
    test_write_bypass();
    test_x0_write();
    test_dual_bypass();
    test_hc_counter();
    test_hc_wrap();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/writeback_regfile.md
# writeback_regfile

Writeback stage and architectural register file of the RV32 pipeline. It consumes the memory stage outputs (`rd_data`, `w_reg`, `dst_addrD`), commits them to a 32×32 register file, and serves two bypassed read ports to decode. It also owns the free-running hardware cycle counter whose value drives `hc_OUT_data` into the memory stage for `lw` from `HARDWARE_COUNTER_ADDR`. It also owns a retired-write counter for benchmark instrumentation.

## Interface
Parameters:
- `SP_INIT`, 32'h0001_0000: reset value of x2 (stack pointer).
- `GP_INIT`, 32'h0000_0000: reset value of x3 (global pointer).

Ports:
- `clk` in 1: single clock; all state updates on posedge.
- `rst_n` in 1: reset; asynchronous, active-low.
- `rd_data` in 32: writeback data from the memory stage.
- `w_reg` in 1: writeback enable from the memory stage.
- `dst_addrD` in 5: writeback destination register.
- `rs1_addr` in 5: decode read port 1 address.
- `rs2_addr` in 5: decode read port 2 address.
- `rs1_data` out 32: read port 1 data (combinational, bypassed).
- `rs2_data` out 32: read port 2 data (combinational, bypassed).
- `hc_clear` in 1: synchronous clear of the cycle counter.
- `hc_OUT_data` out 32: cycle counter value, registered.
- `retire_count` out 32: number of committed non-x0 writes, registered.

## Operation
- Register file: 32 entries × 32 bit. x0 reads as 0 and is never written.
- Write: on posedge, when `w_reg`=1 and `dst_addrD`≠0, `regs[dst_addrD]` ← `rd_data`. When `w_reg`=0 or `dst_addrD`=0, no entry changes.
- Read, per port:
  - addr=0 → 0.
  - else if `w_reg`=1 and addr=`dst_addrD` → `rd_data` (write-first bypass).
  - else → `regs[addr]`.
- Both ports may bypass simultaneously, to the same or different addresses.
- Cycle counter: `hc_OUT_data` increments by 1 every cycle, modulo 2^32. 32'hFFFF_FFFF wraps to 0 with no flag.
  - `hc_clear`=1 loads 0 on the next edge. Clear takes priority over increment.
- Retire counter: `retire_count` increments by 1 on every edge where a write actually commits (`w_reg`=1, `dst_addrD`≠0). It wraps modulo 2^32 and is not affected by `hc_clear`.
- Reset (`rst_n`=0, asynchronous):
  - regs ← 0, except x2 ← `SP_INIT` and x3 ← `GP_INIT`.
  - `hc_OUT_data` ← 0; `retire_count` ← 0.
  - Read ports stay combinational. During reset they return reset contents, and bypass still applies if `w_reg`=1.
- Reset asserted mid-operation discards any pending write in that cycle. After deassertion, the first counted edge gives `hc_OUT_data`=1.

## Timing
- Writeback latency: data presented with `w_reg` is visible on a read port in the same cycle (bypass) and in the array from the next edge.
- Read ports: zero latency, pure combinational from addresses, array and bypass inputs.
- `hc_OUT_data` is a register output. A `lw` sampling it in the memory stage at edge N captures the counter value held during cycle N-1→N.
- No handshakes, stalls or backpressure: one writeback accepted every cycle.
- Async reset assert takes effect immediately. Deassert is sampled synchronously; release is timed to `clk` by the reset synchronizer outside this block.

## Test plan
- Reset with defaults → `rs1_addr`=2 reads 32'h0001_0000. `rs2_addr`=3 reads 0. x1, x31 read 0. `hc_OUT_data`=0, `retire_count`=0.
- Write x5 ← 32'hDEAD_BEEF with `rs1_addr`=5 in the same cycle → `rs1_data`=32'hDEAD_BEEF before the edge. After the edge with `w_reg`=0, still 32'hDEAD_BEEF. `retire_count`=1.
- Write x0 ← 32'h1234_5678 with `rs1_addr`=0 → `rs1_data`=0 in that cycle and after. `retire_count` unchanged.
- Both ports at x7 while writing x7 ← 32'h0000_00A5 → both outputs 32'h0000_00A5 combinationally.
- Release reset and run 10 cycles → `hc_OUT_data`=10. Pulse `hc_clear` one cycle → 0, then 1 on the following edge. Force counter to 32'hFFFF_FFFF via a long run or a hierarchical force, one edge → 0.
- Assert `rst_n`=0 asynchronously between edges after x9 was written → x9 reads 0 immediately, counters 0. The write pending with reset held does not commit.
